// File: rtl/aes_req_arbiter.sv
// -----------------------------------------------------------------------------
// aes_req_arbiter
//   Shares one AES-128 core between two requesters. Requests are granted
//   round-robin, issued to the core with a start/done handshake under a
//   watchdog, and answered on the owning channel's response handshake. The
//   last key loaded into the core is cached so the key schedule only re-runs
//   when the key actually changes.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/req_ready [1:0]  per-channel request handshake (ready is comb)
//   req_enc [1:0]              per-channel direction, 1 = encrypt
//   req_data_0/1, req_key_0/1  per-channel block and key
//   core_start                 one-cycle start pulse to the core
//   core_key_change            with core_start: run the key schedule first
//   core_sel_cypher            direction to the core
//   core_key, core_data        key/block to the core, stable until done
//   core_done, core_result     completion pulse and result from the core
//   rsp_valid/rsp_ready [1:0]  per-channel response handshake
//   rsp_data, rsp_err          shared response block, timeout flag
//   key_reload_cnt             saturating count of key-schedule reloads
// -----------------------------------------------------------------------------
module aes_req_arbiter #(
  parameter int TIMEOUT_CYC = 64,
  parameter int DATA_W      = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_enc,
  input  logic [DATA_W-1:0] req_data_0,
  input  logic [DATA_W-1:0] req_data_1,
  input  logic [DATA_W-1:0] req_key_0,
  input  logic [DATA_W-1:0] req_key_1,
  output logic              core_start,
  output logic              core_key_change,
  output logic              core_sel_cypher,
  output logic [DATA_W-1:0] core_key,
  output logic [DATA_W-1:0] core_data,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [7:0]        key_reload_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Last watchdog value at which WAIT still gives the core a chance.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYC - 1);

  state_t            state, state_nxt;
  logic              last_grant;   // channel served most recently
  logic              grant;        // channel that would win this cycle
  logic              owner;        // channel owning the request in flight
  logic [DATA_W-1:0] cache_key;
  logic              cache_valid;
  logic [7:0]        wdog;
  logic              hs_req;
  logic              hs_rsp;
  logic              timeout;
  logic [DATA_W-1:0] sel_key;
  logic [DATA_W-1:0] sel_data;

  // Round-robin: on a tie the channel not served last wins; otherwise the
  // single requesting channel wins.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it holding a value (no latch).
  always_comb begin
    grant = req_valid[1];
    if (req_valid == 2'b11) grant = ~last_grant;
  end

  assign sel_key  = grant ? req_key_1  : req_key_0;
  assign sel_data = grant ? req_data_1 : req_data_0;
  assign hs_req   = |(req_valid & req_ready);
  assign hs_rsp   = rsp_valid[owner] & rsp_ready[owner];
  // core_done in the last watchdog cycle still counts as a completion.
  assign timeout  = (wdog == WD_LAST) && !core_done;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (hs_req) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (core_done || timeout) state_nxt = ST_RESP;
      ST_RESP:  if (hs_rsp) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Combinational output: request accept. Held low during reset so that
  // every output reads 0 while reset is asserted.
  always_comb begin
    req_ready = 2'b00;
    if (state == ST_IDLE && !reset && req_valid != 2'b00) req_ready[grant] = 1'b1;
  end

  // Registered outputs, key cache and watchdog.
  // NOTE: the key cache is reset together with its valid flag; a reset in
  // mid-operation must leave the cache invalid and the outputs at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant      <= 1'b1;
      owner           <= 1'b0;
      cache_key       <= '0;
      cache_valid     <= 1'b0;
      wdog            <= '0;
      core_start      <= 1'b0;
      core_key_change <= 1'b0;
      core_sel_cypher <= 1'b0;
      core_key        <= '0;
      core_data       <= '0;
      rsp_valid       <= 2'b00;
      rsp_data        <= '0;
      rsp_err         <= 1'b0;
      key_reload_cnt  <= '0;
    end else begin
      core_start      <= 1'b0;
      core_key_change <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (hs_req) begin
            owner           <= grant;
            core_key        <= sel_key;
            core_data       <= sel_data;
            core_sel_cypher <= req_enc[grant];
            core_start      <= 1'b1;
            core_key_change <= !cache_valid || (sel_key != cache_key);
          end
        end
        ST_ISSUE: begin
          wdog <= '0;
          if (core_key_change) begin
            cache_key   <= core_key;
            cache_valid <= 1'b1;
            if (key_reload_cnt != 8'hff) key_reload_cnt <= key_reload_cnt + 8'd1;
          end
        end
        ST_WAIT: begin
          if (core_done) begin
            rsp_data  <= core_result;
            rsp_err   <= 1'b0;
            rsp_valid <= owner ? 2'b10 : 2'b01;
          end else if (timeout) begin
            // The core may be left mid key schedule, so its key is suspect.
            rsp_data    <= '0;
            rsp_err     <= 1'b1;
            cache_valid <= 1'b0;
            rsp_valid   <= owner ? 2'b10 : 2'b01;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        ST_RESP: begin
          if (hs_rsp) begin
            rsp_valid  <= 2'b00;
            last_grant <= owner;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_aes_req_arbiter
//   Directed scenarios followed by randomized transactions. A small model of
//   the arbiter (round-robin pointer, cached key, reload count) predicts each
//   grant, key-change flag and response; a stand-in core returns a fixed
//   function of block/key/direction after a chosen latency, or never.
// -----------------------------------------------------------------------------
module tb_aes_req_arbiter;

  localparam int TMO = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_enc;
  logic [127:0] req_data_0, req_data_1, req_key_0, req_key_1;
  logic         core_start, core_key_change, core_sel_cypher;
  logic [127:0] core_key, core_data;
  logic         core_done;
  logic [127:0] core_result;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [127:0] rsp_data;
  logic         rsp_err;
  logic [7:0]   key_reload_cnt;

  aes_req_arbiter #(.TIMEOUT_CYC(TMO), .DATA_W(128)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_enc        (req_enc),
    .req_data_0     (req_data_0),
    .req_data_1     (req_data_1),
    .req_key_0      (req_key_0),
    .req_key_1      (req_key_1),
    .core_start     (core_start),
    .core_key_change(core_key_change),
    .core_sel_cypher(core_sel_cypher),
    .core_key       (core_key),
    .core_data      (core_data),
    .core_done      (core_done),
    .core_result    (core_result),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .key_reload_cnt (key_reload_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic         m_last;
  logic         m_valid;
  logic [127:0] m_key;
  int           m_cnt;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] fake_core(input logic [127:0] d, input logic [127:0] k,
                                             input logic e);
    return e ? (d ^ k) : ({d[63:0], d[127:64]} ^ ~k);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    m_last  = 1'b1;
    m_valid = 1'b0;
    m_key   = '0;
    m_cnt   = 0;
  endtask

  task automatic check_outputs_zero();
    check("rst_req_ready", 128'(req_ready), 128'(0));
    check("rst_core_start", 128'(core_start), 128'(0));
    check("rst_key_change", 128'(core_key_change), 128'(0));
    check("rst_sel_cypher", 128'(core_sel_cypher), 128'(0));
    check("rst_core_key", core_key, 128'(0));
    check("rst_core_data", core_data, 128'(0));
    check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    check("rst_rsp_data", rsp_data, 128'(0));
    check("rst_rsp_err", 128'(rsp_err), 128'(0));
    check("rst_reload_cnt", 128'(key_reload_cnt), 128'(0));
  endtask

  // One full transaction, entered and left at a negedge with the DUT idle.
  // lat: cycles from core_start to core_done (1..TMO), anything else = never.
  task automatic txn(input logic [1:0] vmask, input logic [1:0] enc,
                     input logic [127:0] d0, input logic [127:0] d1,
                     input logic [127:0] k0, input logic [127:0] k1,
                     input int lat, input int rdy_delay, input logic [1:0] post_mask);
    logic         g;
    logic [1:0]   oh;
    logic [127:0] kg, dg, exp_data;
    logic         exp_kc, exp_err, timed_out;
    int           n, exp_n;
    g         = (vmask == 2'b11) ? ~m_last : vmask[1];
    oh        = g ? 2'b10 : 2'b01;
    kg        = g ? k1 : k0;
    dg        = g ? d1 : d0;
    exp_kc    = !m_valid || (kg != m_key);
    timed_out = !(lat >= 1 && lat <= TMO);
    exp_n     = timed_out ? TMO + 1 : lat + 1;

    req_valid  = vmask;
    req_enc    = enc;
    req_data_0 = d0;
    req_data_1 = d1;
    req_key_0  = k0;
    req_key_1  = k1;
    rsp_ready  = 2'b00;
    #1;
    check("req_ready_grant", 128'(req_ready), 128'(oh));

    @(negedge clk);  // ISSUE cycle
    req_valid = post_mask;
    check("core_start", 128'(core_start), 128'(1));
    check("core_key_change", 128'(core_key_change), 128'(exp_kc));
    check("core_sel_cypher", 128'(core_sel_cypher), 128'(enc[g]));
    check("core_key", core_key, kg);
    check("core_data", core_data, dg);
    check("req_ready_issue", 128'(req_ready), 128'(0));
    if (exp_kc) begin
      m_key   = kg;
      m_valid = 1'b1;
      if (m_cnt < 255) m_cnt++;
    end

    n = 0;
    while (rsp_valid == 2'b00 && n <= 300) begin
      core_done   = (n == lat);
      core_result = fake_core(dg, kg, enc[g]);
      @(negedge clk);
      n++;
    end
    core_done = 1'b0;
    check("cycles_to_rsp", 128'(n), 128'(exp_n));

    if (timed_out) begin
      exp_data = '0;
      exp_err  = 1'b1;
      m_valid  = 1'b0;
    end else begin
      exp_data = fake_core(dg, kg, enc[g]);
      exp_err  = 1'b0;
    end
    check("rsp_valid", 128'(rsp_valid), 128'(oh));
    check("rsp_data", rsp_data, exp_data);
    check("rsp_err", 128'(rsp_err), 128'(exp_err));
    check("key_reload_cnt", 128'(key_reload_cnt), 128'(m_cnt));
    check("core_key_stable", core_key, kg);

    rsp_ready = ~oh;  // the other channel's ready must be ignored
    for (int i = 0; i < rdy_delay; i++) begin
      @(negedge clk);
      check("rsp_valid_hold", 128'(rsp_valid), 128'(oh));
      check("rsp_data_hold", rsp_data, exp_data);
      check("req_ready_resp", 128'(req_ready), 128'(0));
    end
    rsp_ready = oh;
    @(negedge clk);
    rsp_ready = 2'b00;
    check("rsp_valid_clear", 128'(rsp_valid), 128'(0));
    m_last = g;
  endtask

  logic [127:0] kpool [3];

  initial begin
    reset       = 1'b1;
    req_valid   = 2'b11;
    req_enc     = 2'b00;
    req_data_0  = '0;
    req_data_1  = '0;
    req_key_0   = '0;
    req_key_1   = '0;
    core_done   = 1'b0;
    core_result = '0;
    rsp_ready   = 2'b00;
    model_reset();

    // Reset state, with both channels requesting.
    repeat (2) @(negedge clk);
    check_outputs_zero();
    req_valid = 2'b00;
    reset     = 1'b0;

    // Stray core_done while idle is ignored.
    core_done   = 1'b1;
    core_result = rnd128();
    @(negedge clk);
    core_done = 1'b0;
    @(negedge clk);
    check("stray_done_rsp_valid", 128'(rsp_valid), 128'(0));
    check("stray_done_start", 128'(core_start), 128'(0));

    // Ch0 encrypt K1, then ch1 decrypt K1 (cache hit), then ch1 K2 (reload).
    txn(2'b01, 2'b01, rnd128(), rnd128(), K1, K2, 20, 0, 2'b00);
    txn(2'b10, 2'b00, rnd128(), rnd128(), K2, K1, 5, 1, 2'b00);
    txn(2'b10, 2'b00, rnd128(), rnd128(), K1, K2, 3, 0, 2'b00);

    // Both channels valid continuously: grants alternate 0,1,0,1.
    for (int i = 0; i < 4; i++)
      txn(2'b11, 2'($urandom()), rnd128(), rnd128(), K2, K2, 2, 0, 2'b11);

    // Watchdog expiry, then the same key must reload.
    txn(2'b01, 2'b01, rnd128(), rnd128(), K2, K1, -1, 0, 2'b00);
    txn(2'b01, 2'b01, rnd128(), rnd128(), K2, K1, 4, 0, 2'b00);

    // core_done in the very last watchdog cycle wins over the timeout.
    txn(2'b10, 2'b10, rnd128(), rnd128(), K1, K2, TMO, 0, 2'b00);

    // Response back-pressure on ch0 while ch1 waits; ch1 is accepted next.
    txn(2'b01, 2'b01, rnd128(), rnd128(), K1, K2, 6, 5, 2'b10);
    txn(2'b10, 2'b00, rnd128(), rnd128(), K1, K2, 6, 0, 2'b00);

    // Reset in the middle of WAIT.
    req_valid  = 2'b01;
    req_key_0  = K1;
    req_data_0 = rnd128();
    req_enc    = 2'b01;
    #1;
    check("pre_reset_ready", 128'(req_ready), 128'(1));
    @(negedge clk);
    req_valid = 2'b00;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_outputs_zero();
    @(negedge clk);
    reset       = 1'b0;
    core_done   = 1'b1;
    core_result = rnd128();
    @(negedge clk);
    core_done = 1'b0;
    @(negedge clk);
    check("post_reset_rsp_valid", 128'(rsp_valid), 128'(0));
    check("post_reset_rsp_data", rsp_data, 128'(0));
    model_reset();
    txn(2'b11, 2'b11, rnd128(), rnd128(), K1, K1, 7, 0, 2'b00);

    // Randomized traffic.
    kpool[0] = K1;
    kpool[1] = K2;
    kpool[2] = rnd128();
    for (int t = 0; t < 30; t++) begin
      int r, lat;
      r = int'($urandom_range(0, 9));
      if (r == 0)      lat = -1;
      else if (r == 1) lat = TMO;
      else             lat = int'($urandom_range(1, 12));
      txn(2'($urandom_range(1, 3)), 2'($urandom()), rnd128(), rnd128(),
          kpool[$urandom_range(0, 2)], kpool[$urandom_range(0, 2)],
          lat, int'($urandom_range(0, 3)), 2'($urandom()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
